comp2_scheduler: RTL and testbench

COMP2_SCHEDULER -- requirements
Module: comp2_scheduler

---
 rtl/comp2_scheduler_if.sv | 29 ++
 rtl/comp2_scheduler.sv | 153 +++++++++++++++
 tb/tb_comp2_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comp2_scheduler_if.sv
// Request/grant and result bus between two requesters and the complement scheduler.
interface comp2_scheduler_if #(
  parameter int unsigned WIDTH = 6
) ();
  logic             req0;
  logic             req1;
  logic             op0;
  logic             op1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             owner;
  logic             overflow;
  logic             zero;

  modport master (
    output req0, req1, op0, op1, data0, data1,
    input  gnt0, gnt1, busy, done, result, owner, overflow, zero
  );

  modport slave (
    input  req0, req1, op0, op1, data0, data1,
    output gnt0, gnt1, busy, done, result, owner, overflow, zero
  );
endinterface

// File: rtl/comp2_scheduler.sv
// Two-requester round-robin scheduler feeding a bit-serial one's/two's complement unit.
// One operand is processed LSB first, one bit per clock; result is published with a done pulse.
module comp2_scheduler #(
  parameter int unsigned WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  comp2_scheduler_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             own_q, own_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             last_q, last_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             owner_q, owner_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             win;
  logic             sum;
  logic             cap_op;
  logic [WIDTH-1:0] cap_data;

  // State and registered outputs; last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      carry_q    <= 1'b0;
      res_sh_q   <= '0;
      own_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      last_q     <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      owner_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      carry_q    <= carry_d;
      res_sh_q   <= res_sh_d;
      own_q      <= own_d;
      ovf_pend_q <= ovf_pend_d;
      last_q     <= last_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      owner_q    <= owner_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    carry_d    = carry_q;
    res_sh_d   = res_sh_q;
    own_d      = own_q;
    ovf_pend_d = ovf_pend_q;
    last_d     = last_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done_d     = 1'b0;
    result_d   = result_q;
    owner_d    = owner_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    win        = 1'b0;
    sum        = 1'b0;
    cap_op     = 1'b0;
    cap_data   = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          win        = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          cap_op     = win ? bus.op1 : bus.op0;
          cap_data   = win ? bus.data1 : bus.data0;
          a_d        = cap_data;
          carry_d    = cap_op;
          res_sh_d   = '0;
          cnt_d      = '0;
          own_d      = win;
          last_d     = win;
          ovf_pend_d = cap_op && (cap_data == MIN_NEG);
          gnt0_d     = ~win;
          gnt1_d     = win;
          state_d    = COMP;
        end
      end
      COMP: begin
        // Invert-and-increment one bit at a time; carry out of the MSB is dropped.
        sum      = ~a_q[0] ^ carry_q;
        carry_d  = ~a_q[0] & carry_q;
        a_d      = a_q >> 1;
        res_sh_d = {sum, res_sh_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d    = DONE;
          done_d     = 1'b1;
          result_d   = res_sh_d;
          owner_d    = own_q;
          overflow_d = ovf_pend_q;
          zero_d     = (res_sh_d == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.owner    = owner_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_comp2_scheduler.sv
// Self-checking bench for comp2_scheduler: expected results are queued at grant time
// and compared when done pulses.
module tb_comp2_scheduler;

  localparam int unsigned W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  comp2_scheduler_if #(.WIDTH(W)) bus ();

  comp2_scheduler #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic         owner;
    logic [W-1:0] result;
    logic         overflow;
    logic         zero;
  } exp_t;

  exp_t exp_q[$];
  int asserts = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: one's complement, plus one for two's complement, modulo 2^W.
  function automatic exp_t model(input logic own, input logic op, input logic [W-1:0] d);
    exp_t e;
    logic [W-1:0] r;
    logic [W-1:0] min_neg;
    min_neg = {1'b1, {(W-1){1'b0}}};
    r = ~d;
    if (op) r = r + W'(1);
    e.owner    = own;
    e.result   = r;
    e.overflow = op && (d == min_neg);
    e.zero     = (r == '0);
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest pending expectation.
  always @(posedge clk) begin : monitor
    exp_t e;
    exp_t a;
    #1;
    if (bus.done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
      asserts++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: done=1 with nothing pending at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        a = {bus.owner, bus.result, bus.overflow, bus.zero};
        if (a !== e)
          begin
            failures++;
            $display("FAIL result_check: got owner=%0b result=%b ovf=%0b zero=%0b, expected owner=%0b result=%b ovf=%0b zero=%0b",
                     a.owner, a.result, a.overflow, a.zero, e.owner, e.result, e.overflow, e.zero);
          end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic idx, input logic op, input logic [W-1:0] d, output int gcyc);
    gcyc = -1;
    if (idx) begin bus.op1 = op; bus.data1 = d; bus.req1 = 1'b1; end
    else     begin bus.op0 = op; bus.data0 = d; bus.req0 = 1'b1; end
    for (int i = 0; i < 30; i++) begin
      tick();
      if ((idx ? bus.gnt1 : bus.gnt0) === 1'b1) begin
        gcyc = cyc;
        exp_q.push_back(model(idx, op, d));
        break;
      end
    end
    if (idx) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    asserts++;
    if (gcyc < 0) begin
      failures++;
      $display("FAIL grant_timeout: gnt%0d never asserted, expected within 30 cycles", idx);
    end
  endtask

  task automatic wait_done(input int start_cnt, output int dc);
    dc = -1;
    for (int i = 0; i < 30; i++) begin
      if (done_cnt > start_cnt) begin
        dc = last_done_cyc;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bus.req0 = 0; bus.req1 = 0; bus.op0 = 0; bus.op1 = 0; bus.data0 = '0; bus.data1 = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    asserts++;
    if ({bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.result, bus.owner, bus.overflow, bus.zero} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got gnt=%b%b busy=%b done=%b result=%b owner=%b ovf=%b zero=%b, expected all 0",
               bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.result, bus.owner, bus.overflow, bus.zero);
    end
  endtask

  task automatic test_single();
    int g, dc, n, c0;
    c0 = cyc;
    rst_n = 1'b1;
    n = done_cnt;
    issue(1'b0, 1'b1, 6'b000011, g);
    asserts++;
    if (g != c0 + 1) begin
      failures++;
      $display("FAIL first_capture: grant at cycle %0d, expected %0d", g, c0 + 1);
    end
    asserts++;
    if (bus.gnt1 !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL grant_exclusive: gnt1=%b busy=%b, expected gnt1=0 busy=1", bus.gnt1, bus.busy);
    end
    tick();
    asserts++;
    if (bus.gnt0 !== 1'b0) begin
      failures++;
      $display("FAIL grant_width: gnt0=%b one cycle after grant, expected 0", bus.gnt0);
    end
    wait_done(n, dc);
    asserts++;
    if (dc - g != 6) begin
      failures++;
      $display("FAIL latency: done %0d cycles after capture, expected 6", dc - g);
    end
    tick();
    asserts++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL done_exit: done=%b busy=%b after DONE, expected 0 0", bus.done, bus.busy);
    end
    n = done_cnt;
    issue(1'b1, 1'b0, 6'b100011, g);
    wait_done(n, dc);
    asserts++;
    if (dc - g != 6) begin
      failures++;
      $display("FAIL latency_req1: done %0d cycles after capture, expected 6", dc - g);
    end
    n = done_cnt;
    issue(1'b1, 1'b1, 6'b111111, g);
    wait_done(n, dc);
    asserts++;
    if (dc < 0) begin
      failures++;
      $display("FAIL done_timeout_req1: no done seen, expected one");
    end
  endtask

  task automatic test_round_robin();
    int lastg, ng, idx;
    lastg = -1;
    ng = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.op0 = 1'b0; bus.data0 = 6'b001010;
    bus.op1 = 1'b1; bus.data1 = 6'b000101;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      tick();
      if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) begin
        idx = (bus.gnt1 === 1'b1) ? 1 : 0;
        asserts++;
        if ((bus.gnt0 & bus.gnt1) !== 1'b0 || idx != (ng % 2)) begin
          failures++;
          $display("FAIL rr_order: grant %0d went to gnt0=%b gnt1=%b, expected requester %0d", ng, bus.gnt0, bus.gnt1, ng % 2);
        end
        if (lastg >= 0) begin
          asserts++;
          if (cyc - lastg != 8) begin
            failures++;
            $display("FAIL rr_spacing: captures %0d cycles apart, expected 8", cyc - lastg);
          end
        end
        exp_q.push_back(idx ? model(1'b1, bus.op1, bus.data1) : model(1'b0, bus.op0, bus.data0));
        lastg = cyc;
        ng++;
        if (ng == 4) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      end
      if (lastg >= 0 && cyc - lastg <= 7) begin
        asserts++;
        if (bus.busy !== (cyc - lastg != 7)) begin
          failures++;
          $display("FAIL rr_busy: busy=%b at %0d cycles after capture, expected %b", bus.busy, cyc - lastg, (cyc - lastg != 7));
        end
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    asserts++;
    if (ng != 4) begin
      failures++;
      $display("FAIL rr_count: saw %0d grants, expected 4", ng);
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
  endtask

  task automatic test_boundary();
    int g, dc, n;
    n = done_cnt;
    issue(1'b0, 1'b1, 6'b100000, g);
    wait_done(n, dc);
    n = done_cnt;
    issue(1'b1, 1'b1, 6'b000000, g);
    wait_done(n, dc);
    n = done_cnt;
    issue(1'b0, 1'b0, 6'b111111, g);
    wait_done(n, dc);
    asserts++;
    if (dc - g != 6) begin
      failures++;
      $display("FAIL boundary_latency: done %0d cycles after capture, expected 6", dc - g);
    end
  endtask

  task automatic test_reset_mid();
    int g, n;
    tick();
    n = done_cnt;
    issue(1'b0, 1'b1, 6'b000111, g);
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    asserts++;
    if ({bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.result, bus.owner, bus.overflow, bus.zero} !== '0) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b done=%b result=%b owner=%b ovf=%b zero=%b, expected all 0",
               bus.busy, bus.done, bus.result, bus.owner, bus.overflow, bus.zero);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      asserts++;
      if (bus.busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_reset: busy=%b at cycle %0d, expected 0", bus.busy, cyc);
      end
    end
    asserts++;
    if (done_cnt != n) begin
      failures++;
      $display("FAIL aborted_done: %0d done pulses after abort, expected 0", done_cnt - n);
    end
  endtask

  task automatic test_data_change();
    int g, dc, n;
    n = done_cnt;
    issue(1'b0, 1'b0, 6'b010110, g);
    bus.data0 = 6'b111000;
    bus.op0 = 1'b1;
    wait_done(n, dc);
    asserts++;
    if (dc - g != 6) begin
      failures++;
      $display("FAIL data_change_latency: done %0d cycles after capture, expected 6", dc - g);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_boundary();
    test_reset_mid();
    test_data_change();
    repeat (4) tick();
    asserts++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d results still pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
